// File: rtl/reg8_serial_tx.sv
// reg8_serial_tx: reads back the lab's 8-bit operand register over one serial line.
// Frame: start bit (0), 8 data bits LSB first, optional even-parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles. TX, BUSY and DONE are all registered.
// Define REG8_SERIAL_TX_PARITY_EN to insert the PARITY state between DATA and STOP_BIT.
// Without that macro, the frame is 10*CLKS_PER_BIT cycles and no parity logic exists.

module reg8_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] D,
  input  logic       START,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  // The cycle counter is compared against this value to find the last cycle of a bit.
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    STOP_BIT  = 3'd3
`ifdef REG8_SERIAL_TX_PARITY_EN
    ,
    PARITY    = 3'd4
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_cnt_next;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_next;
  logic        busy_next;
  logic        done_next;
  logic        bit_end;

`ifdef REG8_SERIAL_TX_PARITY_EN
  logic        parity_bit;
  logic        parity_bit_next;
`endif

  // Final cycle of the bit currently on the line.
  assign bit_end = (cyc_cnt == LAST_CNT);

  // State register and every output flop. Reset aborts any frame at once and leaves TX high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      TX         <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
`ifdef REG8_SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cyc_cnt    <= cyc_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      TX         <= tx_next;
      BUSY       <= busy_next;
      DONE       <= done_next;
`ifdef REG8_SERIAL_TX_PARITY_EN
      parity_bit <= parity_bit_next;
`endif
    end
  end

  // Next-state logic. TX is computed one cycle early so each bit reaches the pin on the edge that starts it.
  always_comb begin
    state_next      = state;
    cyc_cnt_next    = bit_end ? 16'd0 : 16'(cyc_cnt + 16'd1);
    bit_cnt_next    = bit_cnt;
    shift_next      = shift;
    tx_next         = TX;
    busy_next       = BUSY;
    done_next       = 1'b0;
`ifdef REG8_SERIAL_TX_PARITY_EN
    parity_bit_next = parity_bit;
`endif

    case (state)
      IDLE: begin
        cyc_cnt_next = 16'd0;
        tx_next      = 1'b1;
        busy_next    = 1'b0;
        if (START) begin
          shift_next      = D;
          bit_cnt_next    = 3'd0;
          state_next      = START_BIT;
          tx_next         = 1'b0;
          busy_next       = 1'b1;
`ifdef REG8_SERIAL_TX_PARITY_EN
          parity_bit_next = ^D;
`endif
        end
      end

      START_BIT: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef REG8_SERIAL_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_bit;
`else
            state_next = STOP_BIT;
            tx_next    = 1'b1;
`endif
          end else begin
            shift_next   = {1'b0, shift[7:1]};
            bit_cnt_next = 3'(bit_cnt + 3'd1);
            tx_next      = shift[1];
          end
        end
      end

`ifdef REG8_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP_BIT;
          tx_next    = 1'b1;
        end
      end
`endif

      STOP_BIT: begin
        if (bit_end) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        cyc_cnt_next = 16'd0;
        tx_next      = 1'b1;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg8_serial_tx.sv
// tb_reg8_serial_tx: self-checking bench for reg8_serial_tx.
// Two instances run side by side: one at 4 clocks per bit, one at 1 clock per bit.
// Frames are pushed to a scoreboard when they are requested and popped when DONE appears.

module tb_reg8_serial_tx;

`ifdef REG8_SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] d4 = 8'h00;
  logic       start4 = 1'b0;
  logic       tx4, busy4, done4;

  logic [7:0] d1 = 8'h00;
  logic       start1 = 1'b0;
  logic       tx1, busy1, done1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q4[$];
  logic [7:0] q1[$];

  logic [43:0] cap4 = '0;
  logic [43:0] lastCap4 = '0;
  int          len4 = 0;
  int          lastLen4 = 0;
  int          doneCnt4 = 0;
  logic [7:0]  expByte4;

  logic [43:0] cap1 = '0;
  int          len1 = 0;
  int          doneCnt1 = 0;
  logic [7:0]  expByte1;

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] dec;
  int         n;
  int         savedDone;

  reg8_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .CLK   (clk),
    .RST_N (rst_n),
    .D     (d4),
    .START (start4),
    .TX    (tx4),
    .BUSY  (busy4),
    .DONE  (done4)
  );

  reg8_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .D     (d1),
    .START (start1),
    .TX    (tx1),
    .BUSY  (busy1),
    .DONE  (done1)
  );

  // The clock has a 10-time-unit period. Rising edges are at 5, 15, 25 and so on.
  always #5 clk = ~clk;

  // Compares one value and keeps the running totals.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model of the line waveform for one frame, one entry per clock cycle.
  function automatic logic [43:0] expFrame(input logic [7:0] data, input int cpb);
    logic [10:0] bits;
    logic [43:0] v;
    v        = '0;
    bits     = '0;
    bits[0]  = 1'b0;
    bits[8:1] = data;
`ifdef REG8_SERIAL_TX_PARITY_EN
    bits[9]  = ^data;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    for (int i = 0; i < FRAME_BITS * cpb; i++) v[i] = bits[i / cpb];
    return v;
  endfunction

  // Requests one frame on the 4-clock instance. Call this just after a falling edge.
  // The frame is accepted on the next rising edge.
  task automatic applyStimulus(input logic [7:0] data);
    d4 = data;
    start4 = 1'b1;
    q4.push_back(data);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Waits a bounded number of falling edges for DONE on the selected instance.
  task automatic waitDone(input bit sel, output int cnt);
    cnt = 0;
    while (!(sel ? done1 : done4) && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    if (!(sel ? done1 : done4)) checkOutput(sel ? "dut1 DONE timeout" : "dut4 DONE timeout", 64'd0, 64'd1);
  endtask

  // Monitor for the 4-clock instance. It records TX on every busy cycle.
  // On DONE it compares the recorded frame with the oldest frame in the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      len4 = 0;
      cap4 = '0;
    end else begin
      if (busy4) begin
        if (len4 < 44) cap4[len4] = tx4;
        len4++;
      end
      if (done4) begin
        doneCnt4++;
        lastLen4 = len4;
        lastCap4 = cap4;
        if (q4.size() == 0) checkOutput("dut4 unexpected frame", 64'd1, 64'd0);
        else begin
          expByte4 = q4.pop_front();
          checkOutput("dut4 frame waveform", 64'(cap4), 64'(expFrame(expByte4, 4)));
        end
        len4 = 0;
        cap4 = '0;
      end
    end
  end

  // Monitor for the 1-clock instance. It uses the same scheme and checks frame length too.
  always @(negedge clk) begin
    if (!rst_n) begin
      len1 = 0;
      cap1 = '0;
    end else begin
      if (busy1) begin
        if (len1 < 44) cap1[len1] = tx1;
        len1++;
      end
      if (done1) begin
        doneCnt1++;
        if (q1.size() == 0) checkOutput("dut1 unexpected frame", 64'd1, 64'd0);
        else begin
          expByte1 = q1.pop_front();
          checkOutput("dut1 frame waveform", 64'(cap1), 64'(expFrame(expByte1, 1)));
          checkOutput("dut1 frame length", 64'(len1), 64'(FRAME_BITS));
        end
        len1 = 0;
        cap1 = '0;
      end
    end
  end

  // If the run stalls, stop with a failure instead of hanging.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    tbl[0] = '{d: 8'hA5, par: 1'b0};
    tbl[1] = '{d: 8'h3C, par: 1'b0};
    tbl[2] = '{d: 8'h07, par: 1'b1};
    tbl[3] = '{d: 8'h03, par: 1'b0};
    tbl[4] = '{d: 8'hFF, par: 1'b0};
    tbl[5] = '{d: 8'h00, par: 1'b0};
    tbl[6] = '{d: 8'h80, par: 1'b1};

    // Hold reset with START high. Both instances must stay idle.
    start4 = 1'b1;
    start1 = 1'b1;
    d4 = 8'hFF;
    d1 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("reset idle dut4", 64'({tx4, busy4, done4}), 64'(3'b100));
      checkOutput("reset idle dut1", 64'({tx1, busy1, done1}), 64'(3'b100));
    end
    start4 = 1'b0;
    start1 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post-reset idle dut4", 64'({tx4, busy4, done4}), 64'(3'b100));
    end

    // Single frame of 8'hA5. DONE must come exactly one frame length after acceptance and last one cycle.
    applyStimulus(8'hA5);
    waitDone(1'b0, n);
    #1;
    checkOutput("A5 DONE latency", 64'(n), 64'(FRAME_BITS * 4));
    checkOutput("A5 busy cycles", 64'(lastLen4), 64'(FRAME_BITS * 4));
    @(negedge clk);
    checkOutput("A5 DONE one cycle", 64'({done4, busy4, tx4}), 64'(3'b001));

    // Table-driven frames. Decode each frame from mid-bit samples.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].d);
      waitDone(1'b0, n);
      #1;
      checkOutput("table frame length", 64'(lastLen4), 64'(FRAME_BITS * 4));
      for (int k = 0; k < 8; k++) dec[k] = lastCap4[(k + 1) * 4 + 2];
      checkOutput("table data bits", 64'(dec), 64'(tbl[i].d));
`ifdef REG8_SERIAL_TX_PARITY_EN
      checkOutput("table parity bit", 64'(lastCap4[9 * 4 + 2]), 64'(tbl[i].par));
`endif
      @(negedge clk);
    end

    // Mid-frame START with new data must be ignored. The 8'h3C frame must not change.
    savedDone = doneCnt4;
    applyStimulus(8'h3C);
    repeat (8) @(negedge clk);
    start4 = 1'b1;
    d4 = 8'hFF;
    repeat (3) @(negedge clk);
    start4 = 1'b0;
    d4 = 8'h00;
    waitDone(1'b0, n);
    #1;
    checkOutput("ignore-busy single DONE", 64'(doneCnt4 - savedDone), 64'd1);
    repeat (60) @(negedge clk);
    checkOutput("ignore-busy no extra frame", 64'({doneCnt4 - savedDone, 31'd0, busy4}), 64'({32'd1, 31'd0, 1'b0}));

    // Back-to-back frames at 1 clock per bit with START held high.
    d1 = 8'h01;
    start1 = 1'b1;
    q1.push_back(8'h01);
    @(negedge clk);
    d1 = 8'h80;
    q1.push_back(8'h80);
    waitDone(1'b1, n);
    #1;
    checkOutput("b2b first DONE latency", 64'(n), 64'(FRAME_BITS));
    checkOutput("b2b idle gap", 64'({tx1, busy1}), 64'(2'b10));
    @(negedge clk);
    checkOutput("b2b restart", 64'({tx1, busy1}), 64'(2'b01));
    start1 = 1'b0;
    waitDone(1'b1, n);
    #1;
    checkOutput("b2b second DONE latency", 64'(n), 64'(FRAME_BITS));
    checkOutput("b2b frame count", 64'(doneCnt1), 64'd2);
    @(negedge clk);

    // Assert reset during data bit 3 of 8'hF0. The outputs must drop without a clock edge.
    applyStimulus(8'hF0);
    repeat (17) @(negedge clk);
    #2;
    checkOutput("F0 bit3 before reset", 64'({tx4, busy4}), 64'(2'b01));
    savedDone = doneCnt4;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", 64'({tx4, busy4, done4}), 64'(3'b100));
    q4.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset no DONE", 64'(doneCnt4 - savedDone), 64'd0);
    @(negedge clk);
    applyStimulus(8'h55);
    waitDone(1'b0, n);
    #1;
    checkOutput("55 after reset latency", 64'(n), 64'(FRAME_BITS * 4));
    checkOutput("55 after reset DONE count", 64'(doneCnt4 - savedDone), 64'd1);
    @(negedge clk);

    checkOutput("dut4 scoreboard drained", 64'(q4.size()), 64'd0);
    checkOutput("dut1 scoreboard drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
